// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: symbol width, frame length helper and
// the serializer state encoding, also used by the UART TX framer.
package alu_pkg;

   localparam int BYTE_W = 8;
   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   // Number of BYTE_W symbols needed to carry a 2*width-bit ALU result.
   function automatic int calc_num_bytes(input int width);
      return (2 * width) / BYTE_W;
   endfunction

   localparam int DEFAULT_NUM_BYTES = calc_num_bytes(DEFAULT_WIDTH);

endpackage

// File: rtl/result_byte_shifter.sv
// Frame holding register: loads a full result, presents its least significant byte,
// shifts one byte per advance and flags the final byte of the frame.
module result_byte_shifter
   import alu_pkg::*;
#(
   parameter int NUM_BYTES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [NUM_BYTES*BYTE_W-1:0]   load_data,
   input  logic                          advance,
   output logic [BYTE_W-1:0]             byte_data,
   output logic                          last
);

   localparam int RES_W = NUM_BYTES * BYTE_W;
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   logic [RES_W-1:0] shift_q;
   logic [IDX_W-1:0] index_q;

   // The index saturates on the last byte; only a fresh load rewinds it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         index_q <= '0;
      end else if (load) begin
         shift_q <= load_data;
         index_q <= '0;
      end else if (advance && !last) begin
         shift_q <= shift_q >> BYTE_W;
         index_q <= index_q + 1'b1;
      end
   end

   assign last      = (index_q == IDX_W'(NUM_BYTES - 1));
   assign byte_data = shift_q[BYTE_W-1:0];

endmodule

// File: rtl/alu_result_serializer.sv
// Captures ALU results and streams them LSB-byte-first over a valid/ready byte link,
// with one pending slot and a sticky overflow flag for results that had nowhere to go.
module alu_result_serializer #(
   parameter int WIDTH  = 16,
   parameter int BYTE_W = 8
) (
   input  logic               clk,
   input  logic               RST,
   input  logic [2*WIDTH-1:0] ALU_OUT,
   input  logic               OUT_VALID,
   input  logic               TX_READY,
   input  logic               OVF_CLR,
   output logic [BYTE_W-1:0]  TX_DATA,
   output logic               TX_VALID,
   output logic               TX_LAST,
   output logic               BUSY,
   output logic               OVF
);

   import alu_pkg::*;

   localparam int RES_W     = 2 * WIDTH;
   localparam int NUM_BYTES = calc_num_bytes(WIDTH);

   if ((RES_W % 8) != 0 || BYTE_W != alu_pkg::BYTE_W) begin : g_bad_params
      $error("alu_result_serializer: 2*WIDTH must be a multiple of 8 and BYTE_W must be 8");
   end

   ser_state_t       state_q, state_d;
   logic [RES_W-1:0] pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic             ovf_q, ovf_d;
   logic             load;
   logic [RES_W-1:0] load_data;
   logic             advance;
   logic             drop;
   logic             last;
   logic [BYTE_W-1:0] byte_data;

   result_byte_shifter #(
      .NUM_BYTES(NUM_BYTES)
   ) u_shifter (
      .clk       (clk),
      .rst       (RST),
      .load      (load),
      .load_data (load_data),
      .advance   (advance),
      .byte_data (byte_data),
      .last      (last)
   );

   // On the last-byte handshake the pending slot has priority over a same-cycle result,
   // which then refills the slot instead of being dropped.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      load        = 1'b0;
      load_data   = ALU_OUT;
      advance     = 1'b0;
      drop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (OUT_VALID) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (TX_READY && last) begin
               if (pend_full_q) begin
                  load      = 1'b1;
                  load_data = pend_q;
                  if (OUT_VALID) begin
                     pend_d = ALU_OUT;
                  end else begin
                     pend_full_d = 1'b0;
                  end
               end else if (OUT_VALID) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               advance = TX_READY;
               if (OUT_VALID) begin
                  if (!pend_full_q) begin
                     pend_d      = ALU_OUT;
                     pend_full_d = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ovf_d = drop | (ovf_q & ~OVF_CLR);
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         ovf_q       <= ovf_d;
      end
   end

   assign TX_VALID = (state_q == SEND);
   assign TX_LAST  = TX_VALID & last;
   assign TX_DATA  = byte_data;
   assign BUSY     = TX_VALID | pend_full_q;
   assign OVF      = ovf_q;

endmodule
